// File: rtl/prefix_pkg.sv
// Shared x86 prefix byte codes and segment-register helpers for the prefix encoder/decoder pair.
package prefix_pkg;

    localparam logic [7:0] PFX_LOCK = 8'hF0;
    localparam logic [7:0] PFX_OPSZ = 8'h66;
    localparam logic [7:0] PFX_ADSZ = 8'h67;
    localparam logic [7:0] PFX_ES   = 8'h26;
    localparam logic [7:0] PFX_CS   = 8'h2E;
    localparam logic [7:0] PFX_SS   = 8'h36;
    localparam logic [7:0] PFX_DS   = 8'h3E;
    localparam logic [7:0] PFX_FS   = 8'h64;
    localparam logic [7:0] PFX_GS   = 8'h65;

    typedef enum logic [2:0] {ES, CS, SS, DS, FS, GS} sreg_t;

    function automatic logic [7:0] seg_prefix(input sreg_t s);
        logic [7:0] code;
        case (s)
            ES:      code = PFX_ES;
            CS:      code = PFX_CS;
            SS:      code = PFX_SS;
            DS:      code = PFX_DS;
            FS:      code = PFX_FS;
            default: code = PFX_GS;
        endcase
        return code;
    endfunction

    // Lowest set bit wins, so ES has the highest priority on a conflicting one-hot field.
    function automatic sreg_t seg_lowest(input logic [5:0] seg);
        sreg_t s;
        if (seg[0])      s = ES;
        else if (seg[1]) s = CS;
        else if (seg[2]) s = SS;
        else if (seg[3]) s = DS;
        else if (seg[4]) s = FS;
        else             s = GS;
        return s;
    endfunction

endpackage

// File: rtl/encode_prefix_stream_if.sv
// Request and byte-stream handshake bundle for the prefix encoder.
interface encode_prefix_stream_if;

    logic       req_valid;
    logic       req_ready;
    logic       req_lock;
    logic       req_operand_size;
    logic       req_address_size;
    logic [5:0] req_segment;
    logic [7:0] req_opcode;
    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] byte_data;
    logic       byte_is_prefix;
    logic       byte_last;
    logic       seg_conflict;
    logic       done;

    modport master (
        output req_valid, req_lock, req_operand_size, req_address_size, req_segment, req_opcode,
        output byte_ready,
        input  req_ready, byte_valid, byte_data, byte_is_prefix, byte_last, seg_conflict, done
    );

    modport slave (
        input  req_valid, req_lock, req_operand_size, req_address_size, req_segment, req_opcode,
        input  byte_ready,
        output req_ready, byte_valid, byte_data, byte_is_prefix, byte_last, seg_conflict, done
    );

endinterface

// File: rtl/encode_prefix_stream.sv
// Serializes one instruction's prefix attribute set (plus optional opcode) into x86 bytes,
// one byte per handshake.
//
// state | meaning
// IDLE  | ready for a request, no byte on the output
// LOCK  | presenting F0
// SEG   | presenting the segment override byte
// OPSZ  | presenting 66
// ADSZ  | presenting 67
// OPC   | presenting the latched opcode
module encode_prefix_stream
    import prefix_pkg::*;
#(
    parameter bit EMIT_OPCODE = 1'b1,
    parameter bit LOCK_FIRST  = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    encode_prefix_stream_if.slave        bus_io
);

    typedef enum logic [2:0] {IDLE, LOCK, SEG, OPSZ, ADSZ, OPC} state_t;

    state_t     state_q, state_d;
    logic       lock_q, lock_d;
    logic       opsz_q, opsz_d;
    logic       adsz_q, adsz_d;
    logic       segv_q, segv_d;
    sreg_t      seg_q, seg_d;
    logic [7:0] opc_q, opc_d;
    logic       conflict_q, conflict_d;
    logic       done_q, done_d;

    function automatic state_t order_at(input logic [2:0] idx);
        state_t s;
        case (idx)
            3'd0:    s = LOCK_FIRST ? LOCK : SEG;
            3'd1:    s = LOCK_FIRST ? SEG  : OPSZ;
            3'd2:    s = LOCK_FIRST ? OPSZ : ADSZ;
            3'd3:    s = LOCK_FIRST ? ADSZ : LOCK;
            default: s = OPC;
        endcase
        return s;
    endfunction

    function automatic logic present(input state_t s, input logic lk, input logic sv,
                                     input logic os, input logic as);
        logic p;
        case (s)
            LOCK:    p = lk;
            SEG:     p = sv;
            OPSZ:    p = os;
            ADSZ:    p = as;
            OPC:     p = EMIT_OPCODE;
            default: p = 1'b0;
        endcase
        return p;
    endfunction

    // Walks the emission order past cur and returns the first present slot; IDLE when none remain.
    function automatic state_t next_present(input state_t cur, input logic lk, input logic sv,
                                            input logic os, input logic as);
        state_t nxt;
        state_t cand;
        logic   seen;
        nxt  = IDLE;
        seen = (cur == IDLE);
        for (int i = 0; i < 5; i++) begin
            cand = order_at(3'(i));
            if (seen && (nxt == IDLE) && present(cand, lk, sv, os, as)) nxt = cand;
            if (cand == cur) seen = 1'b1;
        end
        return nxt;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            lock_q     <= 1'b0;
            opsz_q     <= 1'b0;
            adsz_q     <= 1'b0;
            segv_q     <= 1'b0;
            seg_q      <= ES;
            opc_q      <= 8'h00;
            conflict_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_q     <= lock_d;
            opsz_q     <= opsz_d;
            adsz_q     <= adsz_d;
            segv_q     <= segv_d;
            seg_q      <= seg_d;
            opc_q      <= opc_d;
            conflict_q <= conflict_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_d     = lock_q;
        opsz_d     = opsz_q;
        adsz_d     = adsz_q;
        segv_d     = segv_q;
        seg_d      = seg_q;
        opc_d      = opc_q;
        conflict_d = 1'b0;
        done_d     = 1'b0;
        if (state_q == IDLE) begin
            if (bus_io.req_valid) begin
                lock_d     = bus_io.req_lock;
                opsz_d     = bus_io.req_operand_size;
                adsz_d     = bus_io.req_address_size;
                segv_d     = |bus_io.req_segment;
                seg_d      = seg_lowest(bus_io.req_segment);
                opc_d      = bus_io.req_opcode;
                conflict_d = |(bus_io.req_segment & (bus_io.req_segment - 6'd1));
                state_d    = next_present(IDLE, bus_io.req_lock, |bus_io.req_segment,
                                          bus_io.req_operand_size, bus_io.req_address_size);
                done_d     = (state_d == IDLE);
            end
        end else if (bus_io.byte_ready) begin
            state_d = next_present(state_q, lock_q, segv_q, opsz_q, adsz_q);
            done_d  = (state_d == IDLE);
        end
    end

    // Byte outputs decode from held state only, so they stay stable across a stall.
    always_comb begin
        bus_io.req_ready      = (state_q == IDLE);
        bus_io.byte_valid     = (state_q != IDLE);
        bus_io.byte_is_prefix = (state_q != IDLE) && (state_q != OPC);
        bus_io.byte_last      = (state_q != IDLE) &&
                                (next_present(state_q, lock_q, segv_q, opsz_q, adsz_q) == IDLE);
        bus_io.seg_conflict   = conflict_q;
        bus_io.done           = done_q;
        case (state_q)
            LOCK:    bus_io.byte_data = PFX_LOCK;
            SEG:     bus_io.byte_data = seg_prefix(seg_q);
            OPSZ:    bus_io.byte_data = PFX_OPSZ;
            ADSZ:    bus_io.byte_data = PFX_ADSZ;
            OPC:     bus_io.byte_data = opc_q;
            default: bus_io.byte_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_encode_prefix_stream.sv
// Directed bench for encode_prefix_stream: three parameterisations share one clock and reset.
module tb_encode_prefix_stream;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    encode_prefix_stream_if ifa ();
    encode_prefix_stream_if ifb ();
    encode_prefix_stream_if ifc ();

    encode_prefix_stream #(.EMIT_OPCODE(1'b1), .LOCK_FIRST(1'b1)) dut_a (.clk_i(clk), .rst_ni(rst_n), .bus_io(ifa));
    encode_prefix_stream #(.EMIT_OPCODE(1'b1), .LOCK_FIRST(1'b0)) dut_b (.clk_i(clk), .rst_ni(rst_n), .bus_io(ifb));
    encode_prefix_stream #(.EMIT_OPCODE(1'b0), .LOCK_FIRST(1'b1)) dut_c (.clk_i(clk), .rst_ni(rst_n), .bus_io(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (ifa.req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b want 1", ifa.req_ready); else pass_cnt++;
        total_cnt++; if (ifa.byte_valid !== 1'b0) $display("FAIL rst_byte_valid: got %b want 0", ifa.byte_valid); else pass_cnt++;
        total_cnt++; if (ifa.byte_data !== 8'h00) $display("FAIL rst_byte_data: got %h want 00", ifa.byte_data); else pass_cnt++;
        total_cnt++; if (ifa.byte_is_prefix !== 1'b0 || ifa.byte_last !== 1'b0) $display("FAIL rst_flags: got pfx=%b last=%b want 0 0", ifa.byte_is_prefix, ifa.byte_last); else pass_cnt++;
        total_cnt++; if (ifa.seg_conflict !== 1'b0 || ifa.done !== 1'b0) $display("FAIL rst_pulses: got conf=%b done=%b want 0 0", ifa.seg_conflict, ifa.done); else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] exp_b [4] = '{8'hF0, 8'h2E, 8'h66, 8'h89};
        ifa.req_valid = 1'b1; ifa.req_lock = 1'b1; ifa.req_operand_size = 1'b1;
        ifa.req_address_size = 1'b0; ifa.req_segment = 6'b000010; ifa.req_opcode = 8'h89;
        tick();
        // Scramble the request after acceptance; the stream must come from latched values.
        ifa.req_valid = 1'b0; ifa.req_lock = 1'b0; ifa.req_address_size = 1'b1;
        ifa.req_segment = 6'b100000; ifa.req_opcode = 8'h00;
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if (ifa.byte_valid !== 1'b1 || ifa.byte_data !== exp_b[i]) $display("FAIL basic_byte%0d: got v=%b d=%h want v=1 d=%h", i, ifa.byte_valid, ifa.byte_data, exp_b[i]); else pass_cnt++;
            total_cnt++; if (ifa.byte_last !== (i == 3) || ifa.byte_is_prefix !== (i != 3)) $display("FAIL basic_flags%0d: got last=%b pfx=%b want %b %b", i, ifa.byte_last, ifa.byte_is_prefix, (i == 3), (i != 3)); else pass_cnt++;
            total_cnt++; if (ifa.done !== 1'b0 || ifa.req_ready !== 1'b0) $display("FAIL basic_busy%0d: got done=%b ready=%b want 0 0", i, ifa.done, ifa.req_ready); else pass_cnt++;
            tick();
        end
        total_cnt++; if (ifa.done !== 1'b1 || ifa.req_ready !== 1'b1 || ifa.byte_valid !== 1'b0) $display("FAIL basic_done: got done=%b ready=%b v=%b want 1 1 0", ifa.done, ifa.req_ready, ifa.byte_valid); else pass_cnt++;
        tick();
        total_cnt++; if (ifa.done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", ifa.done); else pass_cnt++;
    endtask

    task automatic test_opcode_only();
        ifa.req_valid = 1'b1; ifa.req_lock = 1'b0; ifa.req_operand_size = 1'b0;
        ifa.req_address_size = 1'b0; ifa.req_segment = 6'b0; ifa.req_opcode = 8'h90;
        tick();
        ifa.req_valid = 1'b0;
        total_cnt++; if (ifa.byte_valid !== 1'b1 || ifa.byte_data !== 8'h90) $display("FAIL opc_byte: got v=%b d=%h want v=1 d=90", ifa.byte_valid, ifa.byte_data); else pass_cnt++;
        total_cnt++; if (ifa.byte_is_prefix !== 1'b0 || ifa.byte_last !== 1'b1) $display("FAIL opc_flags: got pfx=%b last=%b want 0 1", ifa.byte_is_prefix, ifa.byte_last); else pass_cnt++;
        tick();
        total_cnt++; if (ifa.done !== 1'b1 || ifa.byte_valid !== 1'b0) $display("FAIL opc_done: got done=%b v=%b want 1 0", ifa.done, ifa.byte_valid); else pass_cnt++;
        tick();
    endtask

    task automatic test_seg_conflict();
        logic [7:0] exp_b [3] = '{8'h2E, 8'h67, 8'hA5};
        ifa.req_valid = 1'b1; ifa.req_lock = 1'b0; ifa.req_operand_size = 1'b0;
        ifa.req_address_size = 1'b1; ifa.req_segment = 6'b001010; ifa.req_opcode = 8'hA5;
        tick();
        ifa.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if (ifa.byte_data !== exp_b[i] || ifa.byte_last !== (i == 2)) $display("FAIL conf_byte%0d: got d=%h last=%b want d=%h last=%b", i, ifa.byte_data, ifa.byte_last, exp_b[i], (i == 2)); else pass_cnt++;
            total_cnt++; if (ifa.seg_conflict !== (i == 0)) $display("FAIL conf_pulse%0d: got %b want %b", i, ifa.seg_conflict, (i == 0)); else pass_cnt++;
            tick();
        end
        total_cnt++; if (ifa.done !== 1'b1 || ifa.seg_conflict !== 1'b0) $display("FAIL conf_done: got done=%b conf=%b want 1 0", ifa.done, ifa.seg_conflict); else pass_cnt++;
        tick();
    endtask

    task automatic test_stall();
        ifa.req_valid = 1'b1; ifa.req_lock = 1'b1; ifa.req_operand_size = 1'b1;
        ifa.req_address_size = 1'b0; ifa.req_segment = 6'b000010; ifa.req_opcode = 8'h8B;
        tick();
        ifa.req_valid = 1'b0;
        total_cnt++; if (ifa.byte_data !== 8'hF0) $display("FAIL stall_first: got %h want F0", ifa.byte_data); else pass_cnt++;
        tick();
        ifa.byte_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if (ifa.byte_valid !== 1'b1 || ifa.byte_data !== 8'h2E || ifa.byte_is_prefix !== 1'b1 || ifa.byte_last !== 1'b0) $display("FAIL stall_hold%0d: got v=%b d=%h pfx=%b last=%b want 1 2E 1 0", i, ifa.byte_valid, ifa.byte_data, ifa.byte_is_prefix, ifa.byte_last); else pass_cnt++;
            tick();
        end
        ifa.byte_ready = 1'b1;
        total_cnt++; if (ifa.byte_data !== 8'h2E || ifa.done !== 1'b0) $display("FAIL stall_release: got d=%h done=%b want 2E 0", ifa.byte_data, ifa.done); else pass_cnt++;
        tick();
        total_cnt++; if (ifa.byte_data !== 8'h66) $display("FAIL stall_third: got %h want 66", ifa.byte_data); else pass_cnt++;
        tick();
        total_cnt++; if (ifa.byte_data !== 8'h8B || ifa.byte_last !== 1'b1) $display("FAIL stall_last: got d=%h last=%b want 8B 1", ifa.byte_data, ifa.byte_last); else pass_cnt++;
        tick();
        total_cnt++; if (ifa.done !== 1'b1) $display("FAIL stall_done: got %b want 1", ifa.done); else pass_cnt++;
        tick();
    endtask

    task automatic test_lock_late();
        logic [7:0] exp_b [4] = '{8'h65, 8'h67, 8'hF0, 8'hC7};
        ifb.req_valid = 1'b1; ifb.req_lock = 1'b1; ifb.req_operand_size = 1'b0;
        ifb.req_address_size = 1'b1; ifb.req_segment = 6'b100000; ifb.req_opcode = 8'hC7;
        tick();
        ifb.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if (ifb.byte_valid !== 1'b1 || ifb.byte_data !== exp_b[i] || ifb.byte_last !== (i == 3)) $display("FAIL late_byte%0d: got v=%b d=%h last=%b want 1 %h %b", i, ifb.byte_valid, ifb.byte_data, ifb.byte_last, exp_b[i], (i == 3)); else pass_cnt++;
            tick();
        end
        total_cnt++; if (ifb.done !== 1'b1) $display("FAIL late_done: got %b want 1", ifb.done); else pass_cnt++;
        tick();
    endtask

    task automatic test_prefix_only();
        ifc.req_valid = 1'b1; ifc.req_lock = 1'b0; ifc.req_operand_size = 1'b0;
        ifc.req_address_size = 1'b0; ifc.req_segment = 6'b0; ifc.req_opcode = 8'h77;
        tick();
        ifc.req_valid = 1'b0;
        total_cnt++; if (ifc.byte_valid !== 1'b0 || ifc.done !== 1'b1 || ifc.req_ready !== 1'b1) $display("FAIL empty_req: got v=%b done=%b ready=%b want 0 1 1", ifc.byte_valid, ifc.done, ifc.req_ready); else pass_cnt++;
        tick();
        total_cnt++; if (ifc.done !== 1'b0) $display("FAIL empty_pulse: got %b want 0", ifc.done); else pass_cnt++;
        ifc.req_valid = 1'b1; ifc.req_operand_size = 1'b1; ifc.req_segment = 6'b001000;
        tick();
        ifc.req_valid = 1'b0;
        total_cnt++; if (ifc.byte_data !== 8'h3E || ifc.byte_last !== 1'b0) $display("FAIL pfx_first: got d=%h last=%b want 3E 0", ifc.byte_data, ifc.byte_last); else pass_cnt++;
        tick();
        total_cnt++; if (ifc.byte_data !== 8'h66 || ifc.byte_last !== 1'b1 || ifc.byte_is_prefix !== 1'b1) $display("FAIL pfx_last: got d=%h last=%b pfx=%b want 66 1 1", ifc.byte_data, ifc.byte_last, ifc.byte_is_prefix); else pass_cnt++;
        tick();
        total_cnt++; if (ifc.done !== 1'b1 || ifc.byte_valid !== 1'b0) $display("FAIL pfx_done: got done=%b v=%b want 1 0", ifc.done, ifc.byte_valid); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_midstream();
        ifa.req_valid = 1'b1; ifa.req_lock = 1'b1; ifa.req_operand_size = 1'b1;
        ifa.req_address_size = 1'b0; ifa.req_segment = 6'b000001; ifa.req_opcode = 8'h12;
        tick();
        ifa.req_valid = 1'b0; ifa.req_lock = 1'b0; ifa.req_segment = 6'b0; ifa.req_operand_size = 1'b0;
        total_cnt++; if (ifa.byte_data !== 8'hF0) $display("FAIL mid_first: got %h want F0", ifa.byte_data); else pass_cnt++;
        tick();
        total_cnt++; if (ifa.byte_data !== 8'h26) $display("FAIL mid_second: got %h want 26", ifa.byte_data); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (ifa.byte_valid !== 1'b0 || ifa.byte_data !== 8'h00 || ifa.byte_last !== 1'b0 || ifa.byte_is_prefix !== 1'b0) $display("FAIL mid_abort: got v=%b d=%h last=%b pfx=%b want 0 00 0 0", ifa.byte_valid, ifa.byte_data, ifa.byte_last, ifa.byte_is_prefix); else pass_cnt++;
        total_cnt++; if (ifa.req_ready !== 1'b1 || ifa.done !== 1'b0) $display("FAIL mid_abort_ctl: got ready=%b done=%b want 1 0", ifa.req_ready, ifa.done); else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        total_cnt++; if (ifa.done !== 1'b0 || ifa.byte_valid !== 1'b0) $display("FAIL mid_after: got done=%b v=%b want 0 0", ifa.done, ifa.byte_valid); else pass_cnt++;
        ifa.req_valid = 1'b1; ifa.req_operand_size = 1'b1; ifa.req_opcode = 8'h55;
        tick();
        ifa.req_valid = 1'b0; ifa.req_operand_size = 1'b0;
        total_cnt++; if (ifa.byte_data !== 8'h66 || ifa.byte_last !== 1'b0) $display("FAIL mid_new_first: got d=%h last=%b want 66 0", ifa.byte_data, ifa.byte_last); else pass_cnt++;
        tick();
        total_cnt++; if (ifa.byte_data !== 8'h55 || ifa.byte_last !== 1'b1) $display("FAIL mid_new_last: got d=%h last=%b want 55 1", ifa.byte_data, ifa.byte_last); else pass_cnt++;
        tick();
        total_cnt++; if (ifa.done !== 1'b1) $display("FAIL mid_new_done: got %b want 1", ifa.done); else pass_cnt++;
        tick();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        ifa.req_valid = 1'b0; ifa.req_lock = 1'b0; ifa.req_operand_size = 1'b0; ifa.req_address_size = 1'b0;
        ifa.req_segment = 6'b0; ifa.req_opcode = 8'h00; ifa.byte_ready = 1'b1;
        ifb.req_valid = 1'b0; ifb.req_lock = 1'b0; ifb.req_operand_size = 1'b0; ifb.req_address_size = 1'b0;
        ifb.req_segment = 6'b0; ifb.req_opcode = 8'h00; ifb.byte_ready = 1'b1;
        ifc.req_valid = 1'b0; ifc.req_lock = 1'b0; ifc.req_operand_size = 1'b0; ifc.req_address_size = 1'b0;
        ifc.req_segment = 6'b0; ifc.req_opcode = 8'h00; ifc.byte_ready = 1'b1;
        test_reset();
        test_basic();
        test_opcode_only();
        test_seg_conflict();
        test_stall();
        test_lock_late();
        test_prefix_only();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
